hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  ID-stage hazard controller: complements forwarding by stalling/flushing hazards that forwarding cannot resolve.
//  Covers load-use, taken-branch flush, multicycle mul/div in EX and data-memory wait in MEM.
//  Drives all pipeline-register enable/bubble controls; FSM plus latency counter.
// PARAMETERS
//  MD_LATENCY  3   total EX cycles of a mul/div op (>=1; 1 = no stall)
//  CNT_W       32  width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high
//  IFID_src1    in   5  rs of instruction in ID
//  IFID_src2    in   5  rt of instruction in ID
//  IFID_useSrc2 in   1  ID instruction reads rt as a source
//  IDEX_MemRead in   1  EX instruction is a load
//  IDEX_dest    in   5  EX instruction destination register
//  IDEX_MulDiv  in   1  EX instruction is mul/div
//  branch_taken in   1  branch resolved taken in EX
//  EXMEM_MemReq in   1  MEM instruction accesses data memory
//  mem_ready    in   1  data memory completes access this cycle
//  stallPC      out  1  hold PC
//  stallIFID    out  1  hold IF/ID
//  flushIFID    out  1  zero IF/ID
//  bubbleIDEX   out  1  load NOP into ID/EX
//  holdIDEX     out  1  hold ID/EX
//  bubbleEXMEM  out  1  load NOP into EX/MEM
//  holdEXMEM    out  1  hold EX/MEM
//  bubbleMEMWB  out  1  load NOP into MEM/WB
//  hzState      out  2  FSM state: 0 RUN, 1 MDBUSY, 2 MEMWAIT
// BEHAVIOUR
//  - Registered: FSM state, mdCnt, resumeMD flag. Outputs are combinational from state plus inputs (same-cycle effect).
//  - Reset (async, any state): state=RUN, mdCnt=0, resumeMD=0. All outputs 0 while reset is asserted.
//  - Priority in RUN: memwait > muldiv > branch > load-use. Only one hazard action per cycle.
//  - memwait (any state): EXMEM_MemReq && !mem_ready.
//    Asserts stallPC, stallIFID, holdIDEX, holdEXMEM, bubbleMEMWB.
//    Sets resumeMD = (state==MDBUSY), then goes to MEMWAIT. mdCnt is frozen.
//  - MEMWAIT: same outputs while !mem_ready. In the cycle mem_ready=1, all outputs are 0.
//    Exit goes to MDBUSY if resumeMD, else RUN. branch_taken is ignored (EX frozen; re-presented after exit).
//  - muldiv (RUN, IDEX_MulDiv, MD_LATENCY>1): asserts stallPC, stallIFID, holdIDEX, bubbleEXMEM.
//    Loads mdCnt=MD_LATENCY-2 and goes to MDBUSY.
//  - MDBUSY: if mdCnt!=0, same outputs as muldiv and mdCnt decrements. If mdCnt==0, outputs are 0 and state goes to RUN.
//    Total stalled cycles = MD_LATENCY-1. branch_taken is ignored.
//  - branch (RUN): branch_taken asserts flushIFID and bubbleIDEX. stallPC=0 so the branch target loads.
//    A coincident load-use is suppressed.
//  - load-use (RUN): IDEX_MemRead && IDEX_dest!=0 &&
//    (IDEX_dest==IFID_src1 || (IFID_useSrc2 && IDEX_dest==IFID_src2)).
//    Asserts stallPC, stallIFID, bubbleIDEX for exactly 1 cycle; the inserted bubble clears the condition.
//  - hold and bubble on the same register are never asserted together.
//  - Unused state encoding 3 returns to RUN on the next clock.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds ports stallCycles and flushCount (out, CNT_W each), reset to 0.
//    stallCycles increments every cycle stallPC=1; flushCount increments every cycle flushIFID=1.
//    Both saturate at all-ones.
//  HAZARD_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Load-use: IDEX_MemRead=1, IDEX_dest=8, IFID_src1=8 -> stallPC=stallIFID=bubbleIDEX=1 for 1 cycle.
//    Same stimulus with dest=0, or src2=8 with useSrc2=0 -> no stall.
//  - Branch + load-use same cycle: branch_taken=1 with the load-use match above
//    -> flushIFID=1, bubbleIDEX=1, stallPC=0.
//  - MulDiv, MD_LATENCY=3: IDEX_MulDiv pulse in RUN -> holdIDEX/bubbleEXMEM high for exactly 2 cycles,
//    hzState 0->1->0. MD_LATENCY=1 -> no stall.
//  - Mem wait inside MDBUSY: mem_ready=0 for 4 cycles at MDBUSY mdCnt=1 -> hzState=2 for 4 cycles,
//    then resumes MDBUSY; 1 further stall cycle, then RUN.
//  - Reset mid-MEMWAIT: assert reset asynchronously -> all outputs 0 immediately; hzState=0 and resumeMD=0 after release.
//  - HAZARD_STATS_EN: 3 load-use events + 1 branch -> stallCycles=3, flushCount=1.
//    Preload both counters to all-ones -> they hold.

Source files
------------

// File: rtl/hazard_stall_if.sv
// hazard_stall_if
// Bundles the ID-stage hazard inputs and the pipeline-register control
// outputs of hazard_stall_unit.
//   master : pipeline side, drives hazard inputs, observes controls
//   slave  : hazard_stall_unit, observes hazard inputs, drives controls
// Inputs : IFID_src1/src2/useSrc2, IDEX_MemRead/dest/MulDiv, branch_taken,
//          EXMEM_MemReq, mem_ready
// Outputs: stallPC, stallIFID, flushIFID, bubbleIDEX, holdIDEX,
//          bubbleEXMEM, holdEXMEM, bubbleMEMWB, hzState[1:0]
`timescale 1ns/1ps

interface hazard_stall_if;
    logic [4:0] IFID_src1;
    logic [4:0] IFID_src2;
    logic       IFID_useSrc2;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_dest;
    logic       IDEX_MulDiv;
    logic       branch_taken;
    logic       EXMEM_MemReq;
    logic       mem_ready;

    logic       stallPC;
    logic       stallIFID;
    logic       flushIFID;
    logic       bubbleIDEX;
    logic       holdIDEX;
    logic       bubbleEXMEM;
    logic       holdEXMEM;
    logic       bubbleMEMWB;
    logic [1:0] hzState;

    modport master (
        output IFID_src1, IFID_src2, IFID_useSrc2, IDEX_MemRead, IDEX_dest,
               IDEX_MulDiv, branch_taken, EXMEM_MemReq, mem_ready,
        input  stallPC, stallIFID, flushIFID, bubbleIDEX, holdIDEX,
               bubbleEXMEM, holdEXMEM, bubbleMEMWB, hzState
    );

    modport slave (
        input  IFID_src1, IFID_src2, IFID_useSrc2, IDEX_MemRead, IDEX_dest,
               IDEX_MulDiv, branch_taken, EXMEM_MemReq, mem_ready,
        output stallPC, stallIFID, flushIFID, bubbleIDEX, holdIDEX,
               bubbleEXMEM, holdEXMEM, bubbleMEMWB, hzState
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// ID-stage hazard controller. Stalls or flushes the hazards forwarding
// cannot resolve: data-memory wait in MEM, multicycle mul/div in EX,
// taken-branch flush and load-use. Outputs are combinational from the
// registered state plus current inputs, so they act in the same cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces all controls to 0 while high
//   hz     hazard_stall_if.slave (hazard inputs in, pipeline controls out)
//   stallCycles, flushCount  CNT_W-bit saturating statistics counters,
//                            present only when HAZARD_STATS_EN is defined
//
// Parameters:
//   MD_LATENCY  total EX cycles of a mul/div op (1 = no stall)
//   CNT_W       width of the statistics counters
//
// Optional feature macro: HAZARD_STATS_EN
//
// state   | meaning
// RUN     | normal flow; memwait > muldiv > branch > load-use
// MDBUSY  | mul/div occupying EX; mdCnt counts remaining stall cycles
// MEMWAIT | data memory busy; whole pipe frozen, resumeMD picks exit state
`timescale 1ns/1ps

module hazard_stall_unit #(
    parameter int MD_LATENCY = 3,
    parameter int CNT_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    hazard_stall_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
`endif
);

    localparam int MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam int MD_LOAD  = (MD_LATENCY >= 2) ? (MD_LATENCY - 2) : 0;
    localparam bit MD_STALL = (MD_LATENCY > 1);

    if (MD_LATENCY < 1 || CNT_W < 1) begin : g_param_check
        $error("hazard_stall_unit: MD_LATENCY and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MDBUSY  = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [MD_CNT_W-1:0]   md_cnt;
    logic [MD_CNT_W-1:0]   md_cnt_nxt;
    logic                  resume_md;
    logic                  resume_md_nxt;

    logic mem_wait;
    logic load_use;

    logic stall_pc_c;
    logic stall_ifid_c;
    logic flush_ifid_c;
    logic bubble_idex_c;
    logic hold_idex_c;
    logic bubble_exmem_c;
    logic hold_exmem_c;
    logic bubble_memwb_c;

    assign mem_wait = hz.EXMEM_MemReq && !hz.mem_ready;

    assign load_use = hz.IDEX_MemRead && (hz.IDEX_dest != 5'd0) &&
                      ((hz.IDEX_dest == hz.IFID_src1) ||
                       (hz.IFID_useSrc2 && (hz.IDEX_dest == hz.IFID_src2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            md_cnt    <= '0;
            resume_md <= 1'b0;
        end else begin
            state     <= state_nxt;
            md_cnt    <= md_cnt_nxt;
            resume_md <= resume_md_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        md_cnt_nxt     = md_cnt;
        resume_md_nxt  = resume_md;
        stall_pc_c     = 1'b0;
        stall_ifid_c   = 1'b0;
        flush_ifid_c   = 1'b0;
        bubble_idex_c  = 1'b0;
        hold_idex_c    = 1'b0;
        bubble_exmem_c = 1'b0;
        hold_exmem_c   = 1'b0;
        bubble_memwb_c = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    hold_idex_c    = 1'b1;
                    hold_exmem_c   = 1'b1;
                    bubble_memwb_c = 1'b1;
                    resume_md_nxt  = 1'b0;
                    state_nxt      = ST_MEMWAIT;
                end else if (hz.IDEX_MulDiv && MD_STALL) begin
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    hold_idex_c    = 1'b1;
                    bubble_exmem_c = 1'b1;
                    md_cnt_nxt     = MD_CNT_W'(MD_LOAD);
                    state_nxt      = ST_MDBUSY;
                end else if (hz.branch_taken) begin
                    // PC stays free so the branch target is fetched.
                    flush_ifid_c   = 1'b1;
                    bubble_idex_c  = 1'b1;
                end else if (load_use) begin
                    // The bubble moves the load on, so this clears itself.
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    bubble_idex_c  = 1'b1;
                end
            end

            ST_MDBUSY: begin
                if (mem_wait) begin
                    // mdCnt is left untouched so the mul/div resumes exactly.
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    hold_idex_c    = 1'b1;
                    hold_exmem_c   = 1'b1;
                    bubble_memwb_c = 1'b1;
                    resume_md_nxt  = 1'b1;
                    state_nxt      = ST_MEMWAIT;
                end else if (md_cnt != '0) begin
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    hold_idex_c    = 1'b1;
                    bubble_exmem_c = 1'b1;
                    md_cnt_nxt     = md_cnt - MD_CNT_W'(1);
                end else begin
                    state_nxt      = ST_RUN;
                end
            end

            ST_MEMWAIT: begin
                // EX is frozen here, so branch_taken is re-presented after exit.
                if (!hz.mem_ready) begin
                    stall_pc_c     = 1'b1;
                    stall_ifid_c   = 1'b1;
                    hold_idex_c    = 1'b1;
                    hold_exmem_c   = 1'b1;
                    bubble_memwb_c = 1'b1;
                end else begin
                    state_nxt      = resume_md ? ST_MDBUSY : ST_RUN;
                    resume_md_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Reset masks the controls combinationally so the pipe is quiet at once.
    assign hz.stallPC     = reset ? 1'b0 : stall_pc_c;
    assign hz.stallIFID   = reset ? 1'b0 : stall_ifid_c;
    assign hz.flushIFID   = reset ? 1'b0 : flush_ifid_c;
    assign hz.bubbleIDEX  = reset ? 1'b0 : bubble_idex_c;
    assign hz.holdIDEX    = reset ? 1'b0 : hold_idex_c;
    assign hz.bubbleEXMEM = reset ? 1'b0 : bubble_exmem_c;
    assign hz.holdEXMEM   = reset ? 1'b0 : hold_exmem_c;
    assign hz.bubbleMEMWB = reset ? 1'b0 : bubble_memwb_c;
    assign hz.hzState     = state;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stall_pc_c && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_W'(1);
            end
            if (flush_ifid_c && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
`timescale 1ns/1ps

module tb_hazard_stall_unit;

    // Control bit order: stallPC stallIFID flushIFID bubbleIDEX
    //                    holdIDEX bubbleEXMEM holdEXMEM bubbleMEMWB
    localparam logic [7:0] NO = 8'b0000_0000;
    localparam logic [7:0] LU = 8'b1101_0000;
    localparam logic [7:0] BR = 8'b0011_0000;
    localparam logic [7:0] MD = 8'b1100_1100;
    localparam logic [7:0] MW = 8'b1100_1011;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   sid = 0;
    logic e1_en = 1'b0;
    logic [9:0] e1 = '0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    hazard_stall_if if0();
    hazard_stall_if if1();

    assign if1.IFID_src1    = if0.IFID_src1;
    assign if1.IFID_src2    = if0.IFID_src2;
    assign if1.IFID_useSrc2 = if0.IFID_useSrc2;
    assign if1.IDEX_MemRead = if0.IDEX_MemRead;
    assign if1.IDEX_dest    = if0.IDEX_dest;
    assign if1.IDEX_MulDiv  = if0.IDEX_MulDiv;
    assign if1.branch_taken = if0.branch_taken;
    assign if1.EXMEM_MemReq = if0.EXMEM_MemReq;
    assign if1.mem_ready    = if0.mem_ready;

`ifdef HAZARD_STATS_EN
    wire [1:0] stall_cycles0, flush_count0, stall_cycles1, flush_count1;
`endif

    hazard_stall_unit #(.MD_LATENCY(3), .CNT_W(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .hz    (if0)
`ifdef HAZARD_STATS_EN
        ,
        .stallCycles (stall_cycles0),
        .flushCount  (flush_count0)
`endif
    );

    hazard_stall_unit #(.MD_LATENCY(1), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .hz    (if1)
`ifdef HAZARD_STATS_EN
        ,
        .stallCycles (stall_cycles1),
        .flushCount  (flush_count1)
`endif
    );

    wire [9:0] act0 = {if0.hzState, if0.stallPC, if0.stallIFID, if0.flushIFID,
                       if0.bubbleIDEX, if0.holdIDEX, if0.bubbleEXMEM,
                       if0.holdEXMEM, if0.bubbleMEMWB};
    wire [9:0] act1 = {if1.hzState, if1.stallPC, if1.stallIFID, if1.flushIFID,
                       if1.bubbleIDEX, if1.holdIDEX, if1.bubbleEXMEM,
                       if1.holdEXMEM, if1.bubbleMEMWB};

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (act0 !== e.v) begin
                errors++;
                $display("FAIL ctrl_md3 step %0d: got hz=%0d ctl=%b, want hz=%0d ctl=%b",
                         e.id, act0[9:8], act0[7:0], e.v[9:8], e.v[7:0]);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (act1 !== e.v) begin
                errors++;
                $display("FAIL ctrl_md1 step %0d: got hz=%0d ctl=%b, want hz=%0d ctl=%b",
                         e.id, act1[9:8], act1[7:0], e.v[9:8], e.v[7:0]);
            end
        end
    end

    task automatic step(input logic rst,
                        input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                        input logic mr, input logic [4:0] d, input logic md,
                        input logic br, input logic mq, input logic rdy,
                        input logic [9:0] e);
        @(posedge clk);
        #1;
        reset            = rst;
        if0.IFID_src1    = s1;
        if0.IFID_src2    = s2;
        if0.IFID_useSrc2 = u2;
        if0.IDEX_MemRead = mr;
        if0.IDEX_dest    = d;
        if0.IDEX_MulDiv  = md;
        if0.branch_taken = br;
        if0.EXMEM_MemReq = mq;
        if0.mem_ready    = rdy;
        q0.push_back('{id: 16'(sid), v: e});
        if (e1_en) q1.push_back('{id: 16'(sid), v: e1});
        sid++;
    endtask

    task automatic check_val(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.IFID_src1 = '0; if0.IFID_src2 = '0; if0.IFID_useSrc2 = 1'b0;
        if0.IDEX_MemRead = 1'b0; if0.IDEX_dest = '0; if0.IDEX_MulDiv = 1'b0;
        if0.branch_taken = 1'b0; if0.EXMEM_MemReq = 1'b0; if0.mem_ready = 1'b1;

        //   rst s1 s2 u2 mr d  md br mq rdy  expected {hzState, controls}
        step(1, 8, 0, 0, 1, 8, 0, 0, 0, 1, {2'd0, NO});  // 0 reset masks load-use
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 1 load-use on rs
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 2 idle
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, {2'd0, NO});  // 3 dest 0 never stalls
        step(0, 3, 8, 0, 1, 8, 0, 0, 0, 1, {2'd0, NO});  // 4 rt match, rt unused
        step(0, 3, 8, 1, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 5 rt match, rt used
        step(0, 8, 0, 0, 1, 8, 0, 1, 0, 1, {2'd0, BR});  // 6 branch beats load-use
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd0, BR});  // 7 branch alone
        e1_en = 1'b1; e1 = {2'd0, NO};
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, {2'd0, MD});  // 8 mul/div start
        e1 = {2'd0, BR};
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd1, MD});  // 9 MDBUSY ignores branch
        e1_en = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, NO});  // 10 MDBUSY done
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 11 back in RUN
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, {2'd0, MD});  // 12 mul/div start
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd1, MW});  // 13 memwait at mdCnt=1
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, {2'd2, MW});  // 14 MEMWAIT ignores branch
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd2, MW});  // 15
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd2, MW});  // 16
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, {2'd2, NO});  // 17 ready: exit to MDBUSY
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, MD});  // 18 last mul/div stall
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, NO});  // 19
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 20
        step(0, 8, 0, 0, 1, 8, 1, 1, 1, 0, {2'd0, MW});  // 21 memwait top priority
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, {2'd2, NO});  // 22 exit to RUN
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, {2'd0, MD});  // 23 mul/div re-presented
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, MD});  // 24
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd1, NO});  // 25
        step(0, 8, 0, 0, 1, 8, 0, 0, 1, 1, {2'd0, LU});  // 26 ready access, load-use
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd0, MW});  // 27 enter MEMWAIT
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd2, MW});  // 28
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd0, NO});  // 29 async reset mid-cycle
        #2 reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {2'd0, MW});  // 30 RUN after reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, {2'd2, NO});  // 31 exit to RUN
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 32
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 33 reset clears stats
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 34
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 35
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 36
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 37
        step(0, 3, 8, 1, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 38
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd0, BR});  // 39
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 40
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        check_val("stallCycles_3lu", int'(stall_cycles0), 3);
        check_val("flushCount_1br", int'(flush_count0), 1);
`endif
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 1, {2'd0, LU});  // 41 counter saturated
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd0, BR});  // 42
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd0, BR});  // 43
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, {2'd0, BR});  // 44 flushCount saturates
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {2'd0, NO});  // 45
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        check_val("stallCycles_sat", int'(stall_cycles0), 3);
        check_val("flushCount_sat", int'(flush_count0), 3);
`endif

        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", q0.size(), q1.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
